// File: rtl/ptw_walker_if.sv
// Memory port of the page-table walker: one PTE read request channel plus the
// returning PTE data. The walker is the master; the memory/cache side is the slave.
interface ptw_walker_if #(
    parameter int unsigned PADDR_W = 56
);
    logic               req_valid;
    logic [PADDR_W-1:0] req_addr;
    logic               req_ready;
    logic               resp_valid;
    logic [63:0]        resp_data;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  resp_valid,
        input  resp_data
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output resp_valid,
        output resp_data
    );
endinterface

// File: rtl/ptw_walker.sv
// Sv39 page-table walker. Takes one translation miss at a time, walks up to three
// levels through a single-outstanding memory port and returns the final PTE, the
// level where the walk stopped and a page-fault flag as a one-cycle pulse.
module ptw_walker #(
    parameter int unsigned LEVELS  = 3,
    parameter int unsigned PPN_W   = 44,
    parameter int unsigned VPN_W   = 27,
    parameter int unsigned PADDR_W = 56
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    input  logic [VPN_W-1:0] req_vpn_i,
    output logic             ready_o,
    input  logic [PPN_W-1:0] satp_ppn_i,
    input  logic             flush_i,
    ptw_walker_if.master     mem,
    output logic             resp_valid_o,
    output logic [63:0]      resp_pte_o,
    output logic [1:0]       resp_level_o,
    output logic             resp_error_o
);

    localparam logic [1:0] TopLevel = 2'(LEVELS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StMemReq,
        StMemWait,
        StResp,
        StAbort
    } state_e;

    state_e             state_q;
    logic [VPN_W-1:0]   vpn_q;
    logic [1:0]         level_q;
    logic               mem_req_valid_q;
    logic [PADDR_W-1:0] mem_req_addr_q;
    logic               resp_valid_q;
    logic [63:0]        resp_pte_q;
    logic [1:0]         resp_level_q;
    logic               resp_error_q;

    // 9-bit VPN index used to address the table at a given level.
    function automatic logic [8:0] vpn_idx(input logic [VPN_W-1:0] vpn, input logic [1:0] lvl);
        case (lvl)
            2'd2:    vpn_idx = vpn[26:18];
            2'd1:    vpn_idx = vpn[17:9];
            default: vpn_idx = vpn[8:0];
        endcase
    endfunction

    logic             pte_v, pte_r, pte_w, pte_x;
    logic             pte_invalid, pte_leaf, pte_misaligned, walk_done, walk_fault;
    logic [PPN_W-1:0] pte_ppn;

    assign pte_v   = mem.resp_data[0];
    assign pte_r   = mem.resp_data[1];
    assign pte_w   = mem.resp_data[2];
    assign pte_x   = mem.resp_data[3];
    assign pte_ppn = mem.resp_data[10 +: PPN_W];

    // Classify the incoming PTE against the current level.
    always_comb begin
        pte_invalid    = !pte_v || (pte_w && !pte_r);
        pte_leaf       = pte_r || pte_x;
        pte_misaligned = 1'b0;
        if (level_q == 2'd2) begin
            pte_misaligned = |pte_ppn[17:0];
        end else if (level_q == 2'd1) begin
            pte_misaligned = |pte_ppn[8:0];
        end
        walk_done  = pte_invalid || pte_leaf || (level_q == 2'd0);
        walk_fault = pte_invalid || (pte_leaf && pte_misaligned)
                     || (!pte_leaf && (level_q == 2'd0));
    end

    // Walk FSM with all outputs registered.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q         <= StIdle;
            vpn_q           <= '0;
            level_q         <= '0;
            mem_req_valid_q <= 1'b0;
            mem_req_addr_q  <= '0;
            resp_valid_q    <= 1'b0;
            resp_pte_q      <= '0;
            resp_level_q    <= '0;
            resp_error_q    <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req_valid_i && !flush_i) begin
                        vpn_q           <= req_vpn_i;
                        level_q         <= TopLevel;
                        mem_req_valid_q <= 1'b1;
                        mem_req_addr_q  <= {satp_ppn_i, vpn_idx(req_vpn_i, TopLevel), 3'b000};
                        state_q         <= StMemReq;
                    end
                end
                StMemReq: begin
                    if (flush_i) begin
                        mem_req_valid_q <= 1'b0;
                        // If the request slipped through in the flush cycle, a response is
                        // owed; absorb it so it cannot land on a later walk.
                        state_q         <= mem.req_ready ? StAbort : StIdle;
                    end else if (mem.req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        state_q         <= StMemWait;
                    end
                end
                StMemWait: begin
                    if (flush_i) begin
                        state_q <= mem.resp_valid ? StIdle : StAbort;
                    end else if (mem.resp_valid) begin
                        if (walk_done) begin
                            resp_valid_q <= 1'b1;
                            resp_pte_q   <= mem.resp_data;
                            resp_level_q <= level_q;
                            resp_error_q <= walk_fault;
                            state_q      <= StResp;
                        end else begin
                            level_q         <= level_q - 2'd1;
                            mem_req_valid_q <= 1'b1;
                            mem_req_addr_q  <= {pte_ppn, vpn_idx(vpn_q, level_q - 2'd1), 3'b000};
                            state_q         <= StMemReq;
                        end
                    end
                end
                StResp: begin
                    resp_valid_q <= 1'b0;
                    state_q      <= StIdle;
                end
                StAbort: begin
                    if (mem.resp_valid) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign ready_o       = (state_q == StIdle);
    assign mem.req_valid = mem_req_valid_q;
    assign mem.req_addr  = mem_req_addr_q;
    assign resp_valid_o  = resp_valid_q;
    assign resp_pte_o    = resp_pte_q;
    assign resp_level_o  = resp_level_q;
    assign resp_error_o  = resp_error_q;

endmodule

// File: tb/tb_ptw_walker.sv
// Directed bench for ptw_walker: the bench plays the memory and checks addresses,
// response fields, latencies, flush/reset behaviour against hand-computed values.
module tb_ptw_walker;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [26:0] req_vpn;
    logic        ready;
    logic [43:0] satp;
    logic        flush;
    logic        resp_valid;
    logic [63:0] resp_pte;
    logic [1:0]  resp_level;
    logic        resp_error;

    int checks   = 0;
    int failures = 0;

    ptw_walker_if #(.PADDR_W(56)) mem_if ();

    ptw_walker dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_vpn_i    (req_vpn),
        .ready_o      (ready),
        .satp_ppn_i   (satp),
        .flush_i      (flush),
        .mem          (mem_if),
        .resp_valid_o (resp_valid),
        .resp_pte_o   (resp_pte),
        .resp_level_o (resp_level),
        .resp_error_o (resp_error)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Walk results filled in by do_walk.
    logic [63:0] mem_pte [0:3];
    logic [55:0] w_addr [0:7];
    int          w_nreq;
    bit          w_got;
    int          w_cycle;
    logic [63:0] w_pte;
    logic [1:0]  w_level;
    logic        w_err;
    bit          w_stable;

    // Issue one walk and act as a zero-wait memory (first request optionally stalled).
    task automatic do_walk(input logic [43:0] s, input logic [26:0] v, input int stall);
        int          idx = 0;
        int          stall_left = stall;
        bit          pend = 0;
        bit          seen = 0;
        logic [55:0] hold = '0;
        w_nreq = 0; w_got = 0; w_cycle = -1; w_stable = 1;
        @(negedge clk);
        satp = s; req_vpn = v; req_valid = 1'b1; mem_if.req_ready = 1'b0;
        for (int c = 1; c <= 80 && !w_got; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            mem_if.resp_valid = 1'b0;
            mem_if.req_ready = 1'b0;
            if (resp_valid) begin
                w_got = 1; w_cycle = c; w_pte = resp_pte; w_level = resp_level; w_err = resp_error;
            end
            if (pend) begin
                mem_if.resp_valid = 1'b1;
                mem_if.resp_data  = (idx < 4) ? mem_pte[idx] : 64'h0;
                idx++;
                pend = 0;
            end
            if (mem_if.req_valid) begin
                if (w_nreq == 0) begin
                    if (!seen) begin
                        seen = 1; hold = mem_if.req_addr;
                    end else if (mem_if.req_addr !== hold) begin
                        w_stable = 0;
                    end
                end
                if (w_nreq == 0 && stall_left > 0) begin
                    stall_left--;
                end else begin
                    mem_if.req_ready = 1'b1;
                    if (w_nreq < 8) w_addr[w_nreq] = mem_if.req_addr;
                    w_nreq++;
                    pend = 1;
                end
            end else if (seen && w_nreq == 0) begin
                w_stable = 0;
            end
        end
        mem_if.resp_valid = 1'b0;
        mem_if.req_ready  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 0; req_vpn = '0; satp = '0; flush = 0;
        mem_if.req_ready = 0; mem_if.resp_valid = 0; mem_if.resp_data = '0;
        repeat (2) @(negedge clk);
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %0h expected 1", ready); end
        checks++; if (mem_if.req_valid !== 1'b0) begin failures++; $display("FAIL reset_mem_valid: got %0h expected 0", mem_if.req_valid); end
        checks++; if (mem_if.req_addr !== 56'h0) begin failures++; $display("FAIL reset_mem_addr: got %0h expected 0", mem_if.req_addr); end
        checks++; if ({resp_valid, resp_pte, resp_level, resp_error} !== 68'h0) begin failures++; $display("FAIL reset_resp: got %0h expected 0", {resp_valid, resp_pte, resp_level, resp_error}); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_walk_4k();
        mem_pte[0] = 64'h20000401; mem_pte[1] = 64'h20000801; mem_pte[2] = 64'h200C00CF;
        do_walk(44'h80000, 27'h0040201, 0);
        checks++; if (!w_got) begin failures++; $display("FAIL walk4k_done: got no response expected response"); end
        checks++; if (w_nreq !== 3) begin failures++; $display("FAIL walk4k_nreq: got %0d expected 3", w_nreq); end
        checks++; if (w_addr[0] !== 56'h80000008) begin failures++; $display("FAIL walk4k_addr0: got %0h expected 80000008", w_addr[0]); end
        checks++; if (w_addr[1] !== 56'h80001008) begin failures++; $display("FAIL walk4k_addr1: got %0h expected 80001008", w_addr[1]); end
        checks++; if (w_addr[2] !== 56'h80002008) begin failures++; $display("FAIL walk4k_addr2: got %0h expected 80002008", w_addr[2]); end
        checks++; if (w_pte !== 64'h200C00CF) begin failures++; $display("FAIL walk4k_pte: got %0h expected 200c00cf", w_pte); end
        checks++; if (w_level !== 2'd0 || w_err !== 1'b0) begin failures++; $display("FAIL walk4k_level_err: got %0d/%0d expected 0/0", w_level, w_err); end
        checks++; if (w_cycle !== 7) begin failures++; $display("FAIL walk4k_latency: got %0d expected 7", w_cycle); end
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL walk4k_ready_in_pulse: got %0h expected 0", ready); end
        @(negedge clk);
        checks++; if (ready !== 1'b1 || resp_valid !== 1'b0) begin failures++; $display("FAIL walk4k_after_pulse: got ready=%0h valid=%0h expected ready=1 valid=0", ready, resp_valid); end
        checks++; if (resp_pte !== 64'h200C00CF) begin failures++; $display("FAIL walk4k_pte_hold: got %0h expected 200c00cf", resp_pte); end
    endtask

    task automatic test_leaf_1g();
        mem_pte[0] = 64'h100000CF;
        do_walk(44'h80000, 27'h0040201, 0);
        checks++; if (w_nreq !== 1) begin failures++; $display("FAIL leaf1g_nreq: got %0d expected 1", w_nreq); end
        checks++; if (w_addr[0] !== 56'h80000008) begin failures++; $display("FAIL leaf1g_addr: got %0h expected 80000008", w_addr[0]); end
        checks++; if (w_level !== 2'd2 || w_err !== 1'b0) begin failures++; $display("FAIL leaf1g_level_err: got %0d/%0d expected 2/0", w_level, w_err); end
        checks++; if (w_cycle !== 3) begin failures++; $display("FAIL leaf1g_latency: got %0d expected 3", w_cycle); end
    endtask

    task automatic test_faults();
        logic [1:0] exp_level;
        int         exp_nreq;
        for (int k = 0; k < 4; k++) begin
            mem_pte[0] = 64'h20000401; mem_pte[1] = 64'h20000801;
            case (k)
                0: begin mem_pte[0] = 64'h100004CF; exp_level = 2'd2; exp_nreq = 1; end
                1: begin mem_pte[1] = 64'h0;        exp_level = 2'd1; exp_nreq = 2; end
                2: begin mem_pte[2] = 64'h5;        exp_level = 2'd0; exp_nreq = 3; end
                default: begin mem_pte[2] = 64'h1;  exp_level = 2'd0; exp_nreq = 3; end
            endcase
            do_walk(44'h80000, 27'h0040201, 0);
            checks++; if (!w_got || w_err !== 1'b1) begin failures++; $display("FAIL fault%0d_error: got %0h expected 1", k, w_err); end
            checks++; if (w_level !== exp_level) begin failures++; $display("FAIL fault%0d_level: got %0d expected %0d", k, w_level, exp_level); end
            checks++; if (w_nreq !== exp_nreq) begin failures++; $display("FAIL fault%0d_nreq: got %0d expected %0d", k, w_nreq, exp_nreq); end
        end
    endtask

    task automatic test_backpressure();
        mem_pte[0] = 64'h100000CF;
        do_walk(44'h80000, 27'h0040201, 5);
        checks++; if (!w_stable) begin failures++; $display("FAIL bp_stable: got unstable valid/addr expected stable"); end
        checks++; if (w_nreq !== 1) begin failures++; $display("FAIL bp_nreq: got %0d expected 1", w_nreq); end
        checks++; if (w_cycle !== 8) begin failures++; $display("FAIL bp_latency: got %0d expected 8", w_cycle); end
        checks++; if (w_level !== 2'd2 || w_err !== 1'b0) begin failures++; $display("FAIL bp_level_err: got %0d/%0d expected 2/0", w_level, w_err); end
    endtask

    task automatic test_flush_wait();
        int pulses = 0;
        @(negedge clk);
        satp = 44'h80000; req_vpn = 27'h0040201; req_valid = 1; mem_if.req_ready = 1;
        @(negedge clk);
        req_valid = 0;
        checks++; if (mem_if.req_valid !== 1'b1) begin failures++; $display("FAIL fw_req: got %0h expected 1", mem_if.req_valid); end
        @(negedge clk);
        mem_if.req_ready = 0; flush = 1;
        @(negedge clk);
        flush = 0;
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL fw_abort_busy: got %0h expected 0", ready); end
        mem_if.resp_valid = 1; mem_if.resp_data = 64'h100000CF;
        @(negedge clk);
        mem_if.resp_valid = 0;
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL fw_ready_after: got %0h expected 1", ready); end
        for (int i = 0; i < 4; i++) begin
            if (resp_valid) pulses++;
            @(negedge clk);
        end
        checks++; if (pulses !== 0) begin failures++; $display("FAIL fw_no_resp: got %0d pulses expected 0", pulses); end
        mem_pte[0] = 64'h20000401; mem_pte[1] = 64'h20000801; mem_pte[2] = 64'h200C00CF;
        do_walk(44'h80000, 27'h0040201, 0);
        checks++; if (w_addr[0] !== 56'h80000008 || w_addr[1] !== 56'h80001008 || w_addr[2] !== 56'h80002008) begin
            failures++; $display("FAIL fw_next_addrs: got %0h %0h %0h expected 80000008 80001008 80002008", w_addr[0], w_addr[1], w_addr[2]); end
        checks++; if (w_pte !== 64'h200C00CF || w_err !== 1'b0) begin failures++; $display("FAIL fw_next_resp: got %0h/%0h expected 200c00cf/0", w_pte, w_err); end
    endtask

    task automatic test_flush_memreq();
        @(negedge clk);
        req_valid = 1; mem_if.req_ready = 0;
        @(negedge clk);
        req_valid = 0;
        checks++; if (mem_if.req_valid !== 1'b1) begin failures++; $display("FAIL fm_req: got %0h expected 1", mem_if.req_valid); end
        flush = 1;
        @(negedge clk);
        flush = 0;
        checks++; if (mem_if.req_valid !== 1'b0 || ready !== 1'b1) begin failures++; $display("FAIL fm_drop: got valid=%0h ready=%0h expected valid=0 ready=1", mem_if.req_valid, ready); end
    endtask

    task automatic test_req_flush_idle();
        @(negedge clk);
        req_valid = 1; flush = 1;
        @(negedge clk);
        req_valid = 0; flush = 0;
        checks++; if (mem_if.req_valid !== 1'b0 || ready !== 1'b1) begin failures++; $display("FAIL rfi_no_walk: got valid=%0h ready=%0h expected valid=0 ready=1", mem_if.req_valid, ready); end
        @(negedge clk);
        checks++; if (mem_if.req_valid !== 1'b0) begin failures++; $display("FAIL rfi_still_idle: got %0h expected 0", mem_if.req_valid); end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        @(negedge clk);
        req_valid = 1; mem_if.req_ready = 0;
        @(negedge clk);
        req_valid = 0;
        checks++; if (mem_if.req_valid !== 1'b1) begin failures++; $display("FAIL rm_req: got %0h expected 1", mem_if.req_valid); end
        rst = 1;
        #1;
        checks++; if (ready !== 1'b1 || mem_if.req_valid !== 1'b0 || mem_if.req_addr !== 56'h0) begin failures++; $display("FAIL rm_mem: got ready=%0h valid=%0h addr=%0h expected 1 0 0", ready, mem_if.req_valid, mem_if.req_addr); end
        checks++; if ({resp_valid, resp_pte, resp_level, resp_error} !== 68'h0) begin failures++; $display("FAIL rm_resp: got %0h expected 0", {resp_valid, resp_pte, resp_level, resp_error}); end
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        mem_if.resp_valid = 1; mem_if.resp_data = 64'h100000CF;
        @(negedge clk);
        mem_if.resp_valid = 0;
        for (int i = 0; i < 3; i++) begin
            if (resp_valid) pulses++;
            @(negedge clk);
        end
        checks++; if (pulses !== 0 || ready !== 1'b1) begin failures++; $display("FAIL rm_stale: got pulses=%0d ready=%0h expected 0 1", pulses, ready); end
    endtask

    initial begin
        test_reset();
        test_walk_4k();
        test_leaf_1g();
        test_faults();
        test_backpressure();
        test_flush_wait();
        test_flush_memreq();
        test_req_flush_idle();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
